// File: rtl/clint_mh_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : clint_mh_if                                                    |
// | Brief   : 32-bit register request/response channel used by clint_mh.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface clint_mh_if #(
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/clint_mh.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : clint_mh                                                       |
// | Brief   : Multi-hart CLINT: mtime, per-hart mtimecmp/msip, timer and     |
// |           software interrupt lines. Optional prescaler: CLINT_TICK_DIV_EN|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module clint_mh #(
  parameter int NUM_HART = 2,
  parameter int ADDR_W   = 16,
  parameter int TICK_DIV = 4
) (
  input  wire                 clk,
  input  wire                 rst,
  input  wire                 trigger_i,
  clint_mh_if.slave           bus,
  output logic                trigger_edge_o,
  output logic [NUM_HART-1:0] tmr_irq_o,
  output logic [NUM_HART-1:0] sft_irq_o
);

  localparam logic [31:0] c_mtime_lo = 32'h0000_BFF8;
  localparam logic [31:0] c_mtime_hi = 32'h0000_BFFC;

  if (NUM_HART < 1 || NUM_HART > 16 || TICK_DIV < 2 || TICK_DIV > 256) begin : g_param_check
    $error("clint_mh: parameter out of range");
  end

  logic              s1_q, s2_q, s3_q;
  logic [63:0]       mtime_q, mtime_d;
  logic [63:0]       mtimecmp_q [NUM_HART];
  logic [NUM_HART-1:0] msip_q, tmr_irq_q, sft_irq_q;
  logic              rsp_valid_q, rsp_err_q;
  logic [31:0]       rsp_rdata_q;

  logic              w_tick, w_accept, w_wr, w_mapped;
  logic              w_mtime_lo_hit, w_mtime_hi_hit, w_wr_mtime_lo, w_wr_mtime_hi;
  logic [31:0]       w_addr_full, w_addr, w_rd_data;
  logic [NUM_HART-1:0] w_msip_hit, w_cmp_lo_hit, w_cmp_hi_hit;

  // Two-flop synchronizer plus a delay flop; either level change is a tick source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= trigger_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign trigger_edge_o = s2_q ^ s3_q;

  assign w_accept    = bus.req_valid & bus.req_ready;
  assign w_wr        = w_accept & bus.req_write;
  assign w_addr_full = 32'(bus.req_addr);
  assign w_addr      = w_addr_full & 32'hFFFF_FFFC;

  assign w_mtime_lo_hit = (w_addr == c_mtime_lo);
  assign w_mtime_hi_hit = (w_addr == c_mtime_hi);
  assign w_wr_mtime_lo  = w_wr & w_mtime_lo_hit;
  assign w_wr_mtime_hi  = w_wr & w_mtime_hi_hit;

  for (genvar h = 0; h < NUM_HART; h++) begin : g_hart
    assign w_msip_hit[h]   = (w_addr == 32'(4 * h));
    assign w_cmp_lo_hit[h] = (w_addr == 32'(32'h4000 + 8 * h));
    assign w_cmp_hi_hit[h] = (w_addr == 32'(32'h4004 + 8 * h));
  end

  assign w_mapped = w_mtime_lo_hit | w_mtime_hi_hit |
                    (|w_msip_hit) | (|w_cmp_lo_hit) | (|w_cmp_hi_hit);

`ifdef CLINT_TICK_DIV_EN
  localparam logic [7:0] c_presc_max = 8'(TICK_DIV - 1);
  logic [7:0] presc_q, presc_d;

  // A software write to mtime restarts the prescaler so the next tick is a full period away.
  always_comb begin
    presc_d = presc_q;
    w_tick  = 1'b0;
    if (trigger_edge_o) begin
      if (presc_q == c_presc_max) begin
        presc_d = 8'd0;
        w_tick  = 1'b1;
      end else begin
        presc_d = presc_q + 8'd1;
      end
    end
    if (w_wr_mtime_lo | w_wr_mtime_hi) presc_d = 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) presc_q <= 8'd0;
    else     presc_q <= presc_d;
  end
`else
  assign w_tick = trigger_edge_o;
`endif

  // A write replaces one half and drops any coincident tick.
  always_comb begin
    mtime_d = mtime_q + 64'(w_tick);
    if (w_wr_mtime_lo) mtime_d = {mtime_q[63:32], bus.req_wdata};
    if (w_wr_mtime_hi) mtime_d = {bus.req_wdata, mtime_q[31:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mtime_q <= 64'd0;
    else     mtime_q <= mtime_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msip_q    <= '0;
      tmr_irq_q <= '0;
      sft_irq_q <= '0;
      for (int h = 0; h < NUM_HART; h++) mtimecmp_q[h] <= '1;
    end else begin
      for (int h = 0; h < NUM_HART; h++) begin
        if (w_wr && w_msip_hit[h])   msip_q[h]            <= bus.req_wdata[0];
        if (w_wr && w_cmp_lo_hit[h]) mtimecmp_q[h][31:0]  <= bus.req_wdata;
        if (w_wr && w_cmp_hi_hit[h]) mtimecmp_q[h][63:32] <= bus.req_wdata;
        tmr_irq_q[h] <= (mtime_q >= mtimecmp_q[h]);
      end
      sft_irq_q <= msip_q;
    end
  end

  always_comb begin
    w_rd_data = 32'd0;
    if (w_mtime_lo_hit) w_rd_data = mtime_q[31:0];
    if (w_mtime_hi_hit) w_rd_data = mtime_q[63:32];
    for (int h = 0; h < NUM_HART; h++) begin
      if (w_msip_hit[h])   w_rd_data = {31'd0, msip_q[h]};
      if (w_cmp_lo_hit[h]) w_rd_data = mtimecmp_q[h][31:0];
      if (w_cmp_hi_hit[h]) w_rd_data = mtimecmp_q[h][63:32];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else if (w_accept) begin
      rsp_valid_q <= 1'b1;
      rsp_rdata_q <= bus.req_write ? 32'd0 : w_rd_data;
      rsp_err_q   <= ~w_mapped;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready = ~rsp_valid_q | bus.rsp_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign tmr_irq_o     = tmr_irq_q;
  assign sft_irq_o     = sft_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_clint_mh.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_clint_mh                                                    |
// | Brief   : Self-checking bench for clint_mh (scoreboard + vector table).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_clint_mh;
  localparam int NUM_HART = 2;
  localparam int ADDR_W   = 16;
`ifdef CLINT_TICK_DIV_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1;
`endif

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trigger = 1'b0;
  logic trigger_edge;
  logic [NUM_HART-1:0] tmr_irq, sft_irq;

  int   n_pass = 0;
  int   n_total = 0;
  int   edge_cnt = 0;
  int   txn_id = 0;
  rsp_t exp_q[$];

  clint_mh_if #(.ADDR_W(ADDR_W)) bus ();

  clint_mh #(.NUM_HART(NUM_HART), .ADDR_W(ADDR_W), .TICK_DIV(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .trigger_i      (trigger),
    .bus            (bus),
    .trigger_edge_o (trigger_edge),
    .tmr_irq_o      (tmr_irq),
    .sft_irq_o      (sft_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin : mon
    rsp_t e;
    if (trigger_edge) edge_cnt++;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("rsp%0d_rdata", e.id), 64'(bus.rsp_rdata), 64'(e.rdata));
        check($sformatf("rsp%0d_err", e.id), 64'(bus.rsp_err), 64'(e.err));
      end
    end
  end

  // All drive tasks start and end at posedge+1.
  task automatic bus_txn(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                         input logic [31:0] er, input logic ee);
    rsp_t e;
    bit   done = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        e.id = txn_id; e.rdata = er; e.err = ee;
        exp_q.push_back(e);
        txn_id++;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    if (!done) check("req_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    check("rsp_drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic toggle(input int n);
    for (int i = 0; i < n; i++) begin
      trigger = ~trigger;
      repeat (5) @(posedge clk);
      #1;
    end
  endtask

  vec_t vecs[15];

  initial begin
    rsp_t e;
    bit   found;

    vecs[0]  = '{1'b1, 16'h4000, 32'h0000_1234, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 16'h4000, 32'h0,         32'h0000_1234, 1'b0};
    vecs[2]  = '{1'b0, 16'h4004, 32'h0,         32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{1'b0, 16'h400C, 32'h0,         32'h0,         1'b0};
    vecs[4]  = '{1'b0, 16'h4008, 32'h0,         32'h5,         1'b0};
    vecs[5]  = '{1'b0, 16'h0008, 32'h0,         32'h0,         1'b1};
    vecs[6]  = '{1'b1, 16'h0008, 32'h1,         32'h0,         1'b1};
    vecs[7]  = '{1'b0, 16'h4010, 32'h0,         32'h0,         1'b1};
    vecs[8]  = '{1'b0, 16'hBFF0, 32'h0,         32'h0,         1'b1};
    vecs[9]  = '{1'b0, 16'hBFFB, 32'h0,         32'h10,        1'b0};
    vecs[10] = '{1'b0, 16'hBFFE, 32'h0,         32'h1,         1'b0};
    vecs[11] = '{1'b1, 16'h0006, 32'h3,         32'h0,         1'b0};
    vecs[12] = '{1'b0, 16'h0004, 32'h0,         32'h1,         1'b0};
    vecs[13] = '{1'b1, 16'h2000, 32'hDEAD_BEEF, 32'h0,         1'b1};
    vecs[14] = '{1'b0, 16'h0000, 32'h0,         32'h0,         1'b0};

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_trigger_edge", 64'(trigger_edge), 64'd0);
    check("rst_irqs", 64'({tmr_irq, sft_irq}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Test 1: three ticks
    edge_cnt = 0;
    toggle(3 * DIV);
    check("t1_edge_count", 64'(edge_cnt), 64'(3 * DIV));
    check("t1_tmr_irq", 64'(tmr_irq), 64'd0);
    check("t1_sft_irq", 64'(sft_irq), 64'd0);
    bus_txn(1'b0, 16'hBFF8, 32'h0, 32'd3, 1'b0);
    bus_txn(1'b0, 16'hBFFC, 32'h0, 32'd0, 1'b0);
    drain();

    // Test 2: mtimecmp[1] = 5, watch the irq lag
    bus_txn(1'b1, 16'h400C, 32'h0, 32'h0, 1'b0);
    bus_txn(1'b1, 16'h4008, 32'h5, 32'h0, 1'b0);
    drain();
    toggle(DIV);
    toggle(DIV - 1);
    trigger = ~trigger;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (trigger_edge) found = 1'b1;
    end
    check("t2_edge_seen", 64'(found), 64'd1);
    check("t2_tmr1_tick_cycle", 64'(tmr_irq[1]), 64'd0);
    @(negedge clk);
    check("t2_tmr1_mtime5_cycle", 64'(tmr_irq[1]), 64'd0);
    @(negedge clk);
    check("t2_tmr1_rise", 64'(tmr_irq[1]), 64'd1);
    check("t2_tmr0_low", 64'(tmr_irq[0]), 64'd0);
    @(posedge clk); #1;
    bus_txn(1'b0, 16'hBFF8, 32'h0, 32'd5, 1'b0);
    drain();

    // Test 3: msip[0]
    bus_txn(1'b1, 16'h0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
    @(negedge clk);
    check("t3_sft0_lag", 64'(sft_irq[0]), 64'd0);
    @(negedge clk);
    check("t3_sft0_set", 64'(sft_irq[0]), 64'd1);
    @(posedge clk); #1;
    bus_txn(1'b0, 16'h0000, 32'h0, 32'h1, 1'b0);
    bus_txn(1'b1, 16'h0000, 32'h0, 32'h0, 1'b0);
    drain();
    repeat (2) @(posedge clk);
    #1;
    check("t3_sft0_clear", 64'(sft_irq[0]), 64'd0);

    // Test 4: carry into hi, then a write coinciding with a tick
    bus_txn(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 32'h0, 1'b0);
    bus_txn(1'b1, 16'hBFFC, 32'h0, 32'h0, 1'b0);
    drain();
    toggle(DIV);
    bus_txn(1'b0, 16'hBFFC, 32'h0, 32'h1, 1'b0);
    bus_txn(1'b0, 16'hBFF8, 32'h0, 32'h0, 1'b0);
    drain();
    toggle(DIV - 1);
    trigger = ~trigger;
    @(posedge clk);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 16'hBFF8;
    bus.req_wdata = 32'h10;
    @(negedge clk);
    check("t4_tick_aligned", 64'(trigger_edge), 64'd1);
    check("t4_req_ready", 64'(bus.req_ready), 64'd1);
    e.id = txn_id; e.rdata = 32'h0; e.err = 1'b0;
    exp_q.push_back(e);
    txn_id++;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus_txn(1'b0, 16'hBFF8, 32'h0, 32'h10, 1'b0);
    bus_txn(1'b0, 16'hBFFC, 32'h0, 32'h1, 1'b0);
    drain();

    // Register map table
    for (int i = 0; i < 15; i++)
      bus_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
    drain();
    @(posedge clk); #1;
    check("map_tmr_irq", 64'(tmr_irq), 64'h2);
    check("map_sft_irq", 64'(sft_irq), 64'h2);

    // Test 5: backpressure, unmapped read, reset mid-response
    bus.rsp_ready = 1'b0;
    bus_txn(1'b0, 16'hBFF8, 32'h0, 32'h10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t5_hold%0d_req_ready", i), 64'(bus.req_ready), 64'd0);
      check($sformatf("t5_hold%0d_rsp_valid", i), 64'(bus.rsp_valid), 64'd1);
      check($sformatf("t5_hold%0d_rdata", i), 64'(bus.rsp_rdata), 64'h10);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    drain();
    bus_txn(1'b0, 16'(16'h4000 + 8 * NUM_HART), 32'h0, 32'h0, 1'b1);
    drain();
    bus.rsp_ready = 1'b0;
    bus_txn(1'b0, 16'h4008, 32'h0, 32'h5, 1'b0);
    @(negedge clk);
    check("t5_pending_valid", 64'(bus.rsp_valid), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    trigger = 1'b0;
    exp_q.delete();
    #1;
    check("t5_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("t5_rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("t5_rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    check("t5_rst_irqs", 64'({tmr_irq, sft_irq}), 64'd0);
    check("t5_rst_trigger_edge", 64'(trigger_edge), 64'd0);
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    bus_txn(1'b0, 16'hBFF8, 32'h0, 32'h0, 1'b0);
    bus_txn(1'b0, 16'hBFFC, 32'h0, 32'h0, 1'b0);
    bus_txn(1'b0, 16'h4008, 32'h0, 32'hFFFF_FFFF, 1'b0);
    bus_txn(1'b0, 16'h4000, 32'h0, 32'hFFFF_FFFF, 1'b0);
    bus_txn(1'b0, 16'h0004, 32'h0, 32'h0, 1'b0);
    drain();

`ifdef CLINT_TICK_DIV_EN
    // Test 6: prescaler divide and clear-on-write
    toggle(8);
    bus_txn(1'b0, 16'hBFF8, 32'h0, 32'd2, 1'b0);
    drain();
    toggle(3);
    bus_txn(1'b1, 16'hBFF8, 32'd7, 32'h0, 1'b0);
    drain();
    toggle(3);
    bus_txn(1'b0, 16'hBFF8, 32'h0, 32'd7, 1'b0);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
